// File: rtl/axis_keep_pack.sv
// axis_keep_pack
//
// Packs a sparse AXI-Stream (valid bytes form a contiguous run starting at
// byte 0, as produced by a byte-rotate stage) into dense output beats.
// Partial beats are accumulated until a full beat can be emitted or the
// packet ends. A packet whose tail overflows one output beat costs one extra
// FLUSH cycle, during which the input is stalled.
//
// Parameters
//   DATA_WIDTH : tdata width in bits (multiple of 8, at least 16)
//   USER_WIDTH : tuser width in bits
//
// Ports
//   aclk, areset          : clock, synchronous active-high reset
//   s_axis_*              : sparse input stream (tdata/tuser/tvalid/tready/tlast/tkeep)
//   m_axis_*              : packed, fully registered output stream
module axis_keep_pack #(
  parameter int DATA_WIDTH = 64,
  parameter int USER_WIDTH = 64
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [USER_WIDTH-1:0]   s_axis_tuser,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  input  logic                    s_axis_tlast,
  input  logic [DATA_WIDTH/8-1:0] s_axis_tkeep,
  output logic [DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [USER_WIDTH-1:0]   m_axis_tuser,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic                    m_axis_tlast,
  output logic [DATA_WIDTH/8-1:0] m_axis_tkeep
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int CW    = $clog2(BYTES);       // holds 0..BYTES-1
  localparam int NW    = $clog2(BYTES + 1);   // holds 0..BYTES
  localparam int TW    = $clog2(2 * BYTES);   // holds 0..2*BYTES-1
  localparam logic [TW-1:0] BYTES_T = TW'(BYTES);

  typedef enum logic {ST_ACCUM, ST_FLUSH} state_t;

  state_t                  state_reg, state_next;
  logic [CW-1:0]           cnt_reg, cnt_next;
  // Only the low BYTES-1 bytes are ever non-zero; the top byte stays zero.
  logic [DATA_WIDTH-1:0]   acc_reg, acc_next;
  logic [USER_WIDTH-1:0]   user_reg, user_next;
  logic                    in_pkt_reg, in_pkt_next;
  logic                    rst_done_reg;

  logic [DATA_WIDTH-1:0]   m_data_reg, m_data_next;
  logic [USER_WIDTH-1:0]   m_user_reg, m_user_next;
  logic                    m_valid_reg, m_valid_next;
  logic                    m_last_reg, m_last_next;
  logic [BYTES-1:0]        m_keep_reg, m_keep_next;

  logic [NW-1:0]           n_bytes;
  logic [DATA_WIDTH-1:0]   in_masked;
  logic [2*DATA_WIDTH-1:0] combined;
  logic [TW-1:0]           total;
  logic [USER_WIDTH-1:0]   pkt_user;
  logic                    slot_free;
  logic                    accept;

  function automatic logic [BYTES-1:0] keep_mask(input logic [TW-1:0] k);
    logic [BYTES-1:0] m;
    m = '0;
    for (int i = 0; i < BYTES; i++) begin
      m[i] = (TW'(i) < k);
    end
    return m;
  endfunction

  // Length of the run of ones in tkeep starting at bit 0.
  always_comb begin
    logic run;
    n_bytes = '0;
    run     = 1'b1;
    for (int i = 0; i < BYTES; i++) begin
      if (run && s_axis_tkeep[i]) begin
        n_bytes = n_bytes + NW'(1);
      end else begin
        run = 1'b0;
      end
    end
  end

  // Zero every input byte beyond the run so garbage never reaches the output.
  genvar gi;
  generate
    for (gi = 0; gi < BYTES; gi++) begin : g_mask
      assign in_masked[gi*8 +: 8] = (NW'(gi) < n_bytes) ? s_axis_tdata[gi*8 +: 8] : 8'h00;
    end
  endgenerate

  // Accumulated bytes in the low part, new bytes appended at byte cnt.
  // Low half is the candidate output beat, high half the overflow remainder.
  assign combined = {{DATA_WIDTH{1'b0}}, acc_reg}
                  | ({{DATA_WIDTH{1'b0}}, in_masked} << {cnt_reg, 3'b000});
  assign total    = TW'(cnt_reg) + TW'(n_bytes);

  assign slot_free     = !m_valid_reg || m_axis_tready;
  assign s_axis_tready = rst_done_reg && (state_reg == ST_ACCUM) && slot_free;
  assign accept        = s_axis_tvalid && s_axis_tready;
  // On the first beat of a packet the latched user is not yet available.
  assign pkt_user      = in_pkt_reg ? user_reg : s_axis_tuser;

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    acc_next     = acc_reg;
    user_next    = user_reg;
    in_pkt_next  = in_pkt_reg;
    m_data_next  = m_data_reg;
    m_user_next  = m_user_reg;
    m_valid_next = m_valid_reg;
    m_last_next  = m_last_reg;
    m_keep_next  = m_keep_reg;

    if (m_valid_reg && m_axis_tready) begin
      m_valid_next = 1'b0;
    end

    case (state_reg)
      ST_ACCUM: begin
        if (accept) begin
          in_pkt_next = !s_axis_tlast;
          if (!in_pkt_reg) begin
            user_next = s_axis_tuser;
          end
          if (total >= BYTES_T) begin
            // Full beat available; keep the overflow.
            m_valid_next = 1'b1;
            m_data_next  = combined[DATA_WIDTH-1:0];
            m_keep_next  = '1;
            m_user_next  = pkt_user;
            acc_next     = combined[2*DATA_WIDTH-1:DATA_WIDTH];
            cnt_next     = CW'(total - BYTES_T);
            // Only complete the packet here if nothing is left over.
            m_last_next  = s_axis_tlast && (total == BYTES_T);
            if (s_axis_tlast && (total != BYTES_T)) begin
              state_next = ST_FLUSH;
            end
          end else if (s_axis_tlast) begin
            cnt_next = '0;
            acc_next = '0;
            if (total != '0) begin
              m_valid_next = 1'b1;
              m_data_next  = combined[DATA_WIDTH-1:0];
              m_keep_next  = keep_mask(total);
              m_last_next  = 1'b1;
              m_user_next  = pkt_user;
            end
          end else begin
            acc_next = combined[DATA_WIDTH-1:0];
            cnt_next = CW'(total);
          end
        end
      end
      ST_FLUSH: begin
        if (slot_free) begin
          m_valid_next = 1'b1;
          m_data_next  = acc_reg;
          m_keep_next  = keep_mask(TW'(cnt_reg));
          m_last_next  = 1'b1;
          m_user_next  = user_reg;
          acc_next     = '0;
          cnt_next     = '0;
          state_next   = ST_ACCUM;
        end
      end
      default: state_next = ST_ACCUM;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_reg    <= ST_ACCUM;
      cnt_reg      <= '0;
      acc_reg      <= '0;
      user_reg     <= '0;
      in_pkt_reg   <= 1'b0;
      rst_done_reg <= 1'b0;
      m_data_reg   <= '0;
      m_user_reg   <= '0;
      m_valid_reg  <= 1'b0;
      m_last_reg   <= 1'b0;
      m_keep_reg   <= '0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      acc_reg      <= acc_next;
      user_reg     <= user_next;
      in_pkt_reg   <= in_pkt_next;
      rst_done_reg <= 1'b1;
      m_data_reg   <= m_data_next;
      m_user_reg   <= m_user_next;
      m_valid_reg  <= m_valid_next;
      m_last_reg   <= m_last_next;
      m_keep_reg   <= m_keep_next;
    end
  end

  assign m_axis_tdata  = m_data_reg;
  assign m_axis_tuser  = m_user_reg;
  assign m_axis_tvalid = m_valid_reg;
  assign m_axis_tlast  = m_last_reg;
  assign m_axis_tkeep  = m_keep_reg;

endmodule

// File: tb/tb_axis_keep_pack.sv
// tb_axis_keep_pack
//
// Directed bench for axis_keep_pack (64-bit data, 64-bit user). Output beats
// are collected into queues with the cycle they were consumed in, then
// compared against hand-computed expected beats. One line per transaction.
module tb_axis_keep_pack;

  logic        aclk;
  logic        areset;
  logic [63:0] s_axis_tdata;
  logic [63:0] s_axis_tuser;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic        s_axis_tlast;
  logic [7:0]  s_axis_tkeep;
  logic [63:0] m_axis_tdata;
  logic [63:0] m_axis_tuser;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        m_axis_tlast;
  logic [7:0]  m_axis_tkeep;

  int err_cnt = 0;
  int chk_cnt = 0;
  int cyc     = 0;

  logic [63:0] q_data[$];
  logic [63:0] q_user[$];
  logic [7:0]  q_keep[$];
  logic        q_last[$];
  int          q_cyc[$];

  axis_keep_pack #(.DATA_WIDTH(64), .USER_WIDTH(64)) dut (
    .aclk          (aclk),
    .areset        (areset),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tuser  (s_axis_tuser),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tkeep  (s_axis_tkeep),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tkeep  (m_axis_tkeep)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  always @(posedge aclk) cyc <= cyc + 1;

  // Inputs only change just after a rising edge, so a handshake seen here is
  // the one the next rising edge completes.
  always @(negedge aclk) begin
    if (m_axis_tvalid && m_axis_tready) begin
      q_data.push_back(m_axis_tdata);
      q_user.push_back(m_axis_tuser);
      q_keep.push_back(m_axis_tkeep);
      q_last.push_back(m_axis_tlast);
      q_cyc.push_back(cyc);
      $display("[%0d] out beat data=%h keep=%h last=%0d user=%h",
               cyc, m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic clear_q();
    q_data.delete(); q_user.delete(); q_keep.delete(); q_last.delete(); q_cyc.delete();
  endtask

  task automatic send(input logic [63:0] data, input logic [7:0] keep,
                      input logic last, input logic [63:0] user);
    logic ok;
    ok = 1'b0;
    s_axis_tdata  = data;
    s_axis_tkeep  = keep;
    s_axis_tlast  = last;
    s_axis_tuser  = user;
    s_axis_tvalid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge aclk);
      if (s_axis_tready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("send_timeout", 64'd0, 64'd1);
    @(posedge aclk);
    #1;
    s_axis_tvalid = 1'b0;
    $display("[%0d] in beat data=%h keep=%h last=%0d user=%h accepted=%0d",
             cyc, data, keep, last, user, ok);
  endtask

  task automatic expect_beat(input string tag, input int idx, input logic [63:0] data,
                             input logic [7:0] keep, input logic last, input logic [63:0] user);
    if (idx >= q_data.size()) begin
      check({tag, "_present"}, 64'(q_data.size()), 64'(idx + 1));
    end else begin
      check({tag, "_data"}, q_data[idx], data);
      check({tag, "_keep"}, 64'(q_keep[idx]), 64'(keep));
      check({tag, "_last"}, 64'(q_last[idx]), 64'(last));
      check({tag, "_user"}, q_user[idx], user);
    end
  endtask

  task automatic settle();
    repeat (4) @(posedge aclk);
    #1;
  endtask

  logic [63:0] tp_data [4];

  initial begin
    areset        = 1'b1;
    m_axis_tready = 1'b1;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tuser  = '0;
    s_axis_tlast  = 1'b0;
    s_axis_tkeep  = '0;
    repeat (3) @(posedge aclk);
    #1;
    check("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    check("rst_tdata",  m_axis_tdata, 64'd0);
    check("rst_tkeep",  64'(m_axis_tkeep), 64'd0);
    check("rst_tlast",  64'(m_axis_tlast), 64'd0);
    check("rst_tuser",  m_axis_tuser, 64'd0);
    check("rst_tready", 64'(s_axis_tready), 64'd0);
    areset = 1'b0;
    @(posedge aclk);
    #1;
    check("rst_tready_rise", 64'(s_axis_tready), 64'd1);

    // Pack two half beats; tuser comes from the first beat.
    clear_q();
    send(64'hFFFF_FFFF_4433_2211, 8'h0F, 1'b0, 64'd1);
    send(64'hEEEE_EEEE_8877_6655, 8'h0F, 1'b1, 64'hAA);
    settle();
    check("pack_count", 64'(q_data.size()), 64'd1);
    expect_beat("pack", 0, 64'h8877_6655_4433_2211, 8'hFF, 1'b1, 64'd1);

    // Overflow into FLUSH.
    clear_q();
    send(64'hEEEE_EE05_0403_0201, 8'h1F, 1'b0, 64'd2);
    send(64'h0D0C_0B0A_0908_0706, 8'hFF, 1'b1, 64'd2);
    check("flush_tready", 64'(s_axis_tready), 64'd0);
    @(posedge aclk);
    #1;
    check("after_flush_tready", 64'(s_axis_tready), 64'd1);
    settle();
    check("ovf_count", 64'(q_data.size()), 64'd2);
    expect_beat("ovf0", 0, 64'h0807_0605_0403_0201, 8'hFF, 1'b0, 64'd2);
    expect_beat("ovf1", 1, 64'h0000_000D_0C0B_0A09, 8'h1F, 1'b1, 64'd2);

    // Empty tlast beat closes the packet.
    clear_q();
    send(64'hDDCC_BBAA_9903_0201, 8'h07, 1'b0, 64'd3);
    send(64'hFFFF_FFFF_FFFF_FFFF, 8'h00, 1'b1, 64'd3);
    settle();
    check("late_count", 64'(q_data.size()), 64'd1);
    expect_beat("late", 0, 64'h0000_0000_0003_0201, 8'h07, 1'b1, 64'd3);
    clear_q();
    send(64'h1234_5678_9ABC_DEF0, 8'h00, 1'b1, 64'd9);
    settle();
    check("lone_empty_count", 64'(q_data.size()), 64'd0);

    // Backpressure: output held for 5 cycles, then two beats back to back.
    clear_q();
    m_axis_tready = 1'b0;
    send(64'h1122_3344_5566_7788, 8'hFF, 1'b1, 64'd4);
    fork
      send(64'h99AA_BBCC_DDEE_FF00, 8'hFF, 1'b1, 64'd5);
    join_none
    for (int i = 0; i < 5; i++) begin
      @(negedge aclk);
      check("bp_tvalid", 64'(m_axis_tvalid), 64'd1);
      check("bp_tdata",  m_axis_tdata, 64'h1122_3344_5566_7788);
      check("bp_tuser",  m_axis_tuser, 64'd4);
      check("bp_tready", 64'(s_axis_tready), 64'd0);
    end
    @(posedge aclk);
    #1;
    m_axis_tready = 1'b1;
    settle();
    check("bp_count", 64'(q_data.size()), 64'd2);
    expect_beat("bp0", 0, 64'h1122_3344_5566_7788, 8'hFF, 1'b1, 64'd4);
    expect_beat("bp1", 1, 64'h99AA_BBCC_DDEE_FF00, 8'hFF, 1'b1, 64'd5);
    if (q_cyc.size() == 2) check("bp_gap", 64'(q_cyc[1] - q_cyc[0]), 64'd1);

    // Full throughput.
    clear_q();
    tp_data[0] = 64'h0706_0504_0302_0100;
    tp_data[1] = 64'h0F0E_0D0C_0B0A_0908;
    tp_data[2] = 64'h1716_1514_1312_1110;
    tp_data[3] = 64'h1F1E_1D1C_1B1A_1918;
    for (int i = 0; i < 4; i++) send(tp_data[i], 8'hFF, (i == 3), 64'd6);
    settle();
    check("tp_count", 64'(q_data.size()), 64'd4);
    for (int i = 0; i < 4; i++) expect_beat("tp", i, tp_data[i], 8'hFF, (i == 3), 64'd6);
    if (q_cyc.size() == 4)
      for (int i = 1; i < 4; i++) check("tp_gap", 64'(q_cyc[i] - q_cyc[i-1]), 64'd1);

    // Reset with three bytes buffered.
    clear_q();
    send(64'h0000_0000_00C3_C2C1, 8'h07, 1'b0, 64'd7);
    areset = 1'b1;
    @(posedge aclk);
    #1;
    check("midrst_tvalid", 64'(m_axis_tvalid), 64'd0);
    check("midrst_tready", 64'(s_axis_tready), 64'd0);
    areset = 1'b0;
    @(posedge aclk);
    #1;
    check("midrst_tready_rise", 64'(s_axis_tready), 64'd1);
    send(64'h0102_0304_0506_0708, 8'hFF, 1'b1, 64'd8);
    settle();
    check("midrst_count", 64'(q_data.size()), 64'd1);
    expect_beat("midrst", 0, 64'h0102_0304_0506_0708, 8'hFF, 1'b1, 64'd8);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/axis_keep_pack.md
AXIS_KEEP_PACK -- requirements
Module: axis_keep_pack

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, tdata width in bits; multiple of 8; BYTES = DATA_WIDTH/8.
REQ-002 SHALL have parameter USER_WIDTH, default 64, tuser width in bits.
REQ-003 SHALL have port aclk  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port areset  input  1  synchronous, active-high reset.
REQ-005 SHALL have ports s_axis_tdata/tuser/tvalid/tready/tlast/tkeep  in/in/in/out/in/in  DATA_WIDTH/USER_WIDTH/1/1/1/BYTES  sparse input stream (output of byte-rotate stage).
REQ-006 SHALL have ports m_axis_tdata/tuser/tvalid/tready/tlast/tkeep  out/out/out/in/out/out  same widths  packed output stream.

Function
REQ-007 SHALL take input byte count n = number of consecutive ones in s_axis_tkeep starting at bit 0 (0..BYTES); bytes above the first zero keep bit SHALL be discarded.
REQ-008 SHALL hold an accumulator of BYTES-1 bytes plus count cnt (0..BYTES-1); new bytes are appended at byte position cnt (little-endian, byte 0 = tdata[7:0]).
REQ-009 SHALL be a two-state FSM: ACCUM (reset state) and FLUSH.
REQ-010 SHALL drive s_axis_tready = (state==ACCUM) && (!m_axis_tvalid || m_axis_tready); input accepted when tvalid && tready.
REQ-011 SHALL register all m_axis outputs; an output beat becomes valid the cycle after the input beat that completes it is accepted (latency 1).
REQ-012 On accepted beat with total = cnt+n, not tlast: total<BYTES -> append, cnt=total, no output; total>=BYTES -> emit low BYTES bytes, tkeep all ones, tlast 0, cnt=total-BYTES.
REQ-013 On accepted tlast beat: total==0 -> no output, cnt stays 0; 1<=total<=BYTES -> emit one beat, tkeep=(1<<total)-1, tlast 1, cnt=0.
REQ-014 On accepted tlast beat with total>BYTES: emit full beat tlast 0, store remainder (total-BYTES bytes), enter FLUSH.
REQ-015 In FLUSH, when output slot free (!m_axis_tvalid || m_axis_tready): emit remainder, tkeep=(1<<rem)-1, tlast 1, cnt=0, return to ACCUM.
REQ-016 SHALL latch s_axis_tuser on the first accepted beat of each packet (cnt==0 and previous accepted beat was tlast or post-reset) and drive it on every output beat of that packet.
REQ-017 m_axis_tdata bytes above the tkeep boundary SHALL be zero.
REQ-018 While m_axis_tvalid && !m_axis_tready, all m_axis outputs SHALL be held stable.
REQ-019 m_axis_tvalid SHALL clear on handshake unless a new beat is emitted the same cycle (back-to-back full throughput: one beat per cycle when n==BYTES).

Reset
REQ-020 While areset high at a clock edge: state=ACCUM, cnt=0, accumulator=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tkeep=0, m_axis_tdata=0, m_axis_tuser=0, s_axis_tready=0.
REQ-021 Reset mid-packet or mid-FLUSH SHALL discard all buffered bytes; no partial beat emitted afterwards; first beat after reset starts a new packet.
REQ-022 s_axis_tready SHALL rise the first cycle after areset deasserts.

Verification
REQ-023 Pack: beats tdata 0x44332211 keep 0x0F, then 0x88776655 keep 0x0F tlast, tuser 1 -> one beat 0x8877665544332211 keep 0xFF tlast 1 tuser 1.
REQ-024 Overflow: bytes 01..05 keep 0x1F, then bytes 06..0D keep 0xFF tlast -> beat 0x0807060504030201 keep 0xFF tlast 0, then 0x0D0C0B0A09 keep 0x1F tlast 1; s_axis_tready low during FLUSH.
REQ-025 Empty/late last: bytes 01..03 keep 0x07, then keep 0x00 tlast -> one beat 0x030201 keep 0x07 tlast 1; lone keep 0x00 tlast with cnt 0 -> no output.
REQ-026 Backpressure: m_axis_tready low 5 cycles with valid beat -> outputs stable, s_axis_tready 0; release -> beat consumed, next beat follows one cycle later.
REQ-027 Throughput: 4 consecutive keep 0xFF beats, m_axis_tready 1 -> 4 output beats on 4 consecutive cycles, data unchanged.
REQ-028 Reset mid-packet: 3 bytes buffered, areset pulse 1 cycle -> no output; next packet 0x0102030405060708 keep 0xFF tlast emits unchanged, tuser of new packet.
